// File: rtl/program_loader_pkg.sv
// Shared types and defaults for the program loader.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_MAGIC = 3'd0,
    ST_LEN_HI     = 3'd1,
    ST_LEN_LO     = 3'd2,
    ST_DATA_HI    = 3'd3,
    ST_DATA_LO    = 3'd4,
    ST_CHECKSUM   = 3'd5,
    ST_DONE       = 3'd6,
    ST_ERROR      = 3'd7
  } state_t;

  localparam logic [7:0]  DEFAULT_MAGIC   = 8'hA5;
  localparam int unsigned DEFAULT_TIMEOUT = 65535;

  // True for the states in which a frame is in flight and idle time is counted.
  function automatic logic in_frame(input state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
           (s == ST_DATA_LO) || (s == ST_CHECKSUM);
  endfunction

endpackage

// File: rtl/program_loader_idle_timer.sv
// Loadable idle down-counter; o_expired rises once TIMEOUT_CYCLES enabled
// cycles pass without a reload. TIMEOUT_CYCLES=0 disables it.
module program_loader_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_reload,
  input  logic i_enable,
  output logic o_expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    assign o_expired = 1'b0;
  end else begin : g_on
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] count;

    // Restart while idle-counting is off or on any accepted byte; otherwise count down.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        count     <= CNT_W'(TIMEOUT_CYCLES);
        o_expired <= 1'b0;
      end else if (i_reload || !i_enable) begin
        count     <= CNT_W'(TIMEOUT_CYCLES);
        o_expired <= 1'b0;
      end else if (count != '0) begin
        count     <= count - CNT_W'(1);
        o_expired <= (count == CNT_W'(1));
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Receives a framed byte stream, writes big-endian 16-bit words to program RAM
// and releases the core only after a load with a good checksum.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter logic [7:0]  MAGIC          = DEFAULT_MAGIC,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic                  o_rx_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [15:0]           o_mem_data,
  output logic                  o_core_hold,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int unsigned IDX_W     = ADDR_WIDTH + 1;
  localparam int unsigned MAX_WORDS = 32'(1) << ADDR_WIDTH;

  state_t           state;
  logic [7:0]       len_hi;
  logic [15:0]      len;
  logic [7:0]       sum;
  logic [7:0]       hi;
  logic [IDX_W-1:0] idx;

  logic        accept;
  logic        expired;
  logic [7:0]  sum_next;
  logic [15:0] len_in;
  logic        last_word;

  assign accept    = i_rx_valid & o_rx_ready;
  assign sum_next  = sum + i_rx_data;
  assign len_in    = {len_hi, i_rx_data};
  assign last_word = (16'(idx) + 16'd1) == len;

  program_loader_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_reload (accept),
    .i_enable (in_frame(state)),
    .o_expired(expired)
  );

  // Frame parser, word assembler, checksum and all registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_WAIT_MAGIC;
      len_hi      <= '0;
      len         <= '0;
      sum         <= '0;
      hi          <= '0;
      idx         <= '0;
      o_rx_ready  <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_data  <= '0;
      o_core_hold <= 1'b1;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      o_mem_we   <= 1'b0;
      o_rx_ready <= 1'b1;
      if (expired && !accept && in_frame(state)) begin
        state       <= ST_ERROR;
        o_error     <= 1'b1;
        o_core_hold <= 1'b1;
      end else if (accept) begin
        case (state)
          ST_WAIT_MAGIC: begin
            if (i_rx_data == MAGIC) begin
              state <= ST_LEN_HI;
              sum   <= '0;
              idx   <= '0;
            end
          end
          ST_LEN_HI: begin
            len_hi <= i_rx_data;
            sum    <= sum_next;
            state  <= ST_LEN_LO;
          end
          ST_LEN_LO: begin
            len <= len_in;
            sum <= sum_next;
            if (32'(len_in) > MAX_WORDS) begin
              state   <= ST_ERROR;
              o_error <= 1'b1;
            end else if (len_in == 16'd0) begin
              state <= ST_CHECKSUM;
            end else begin
              state <= ST_DATA_HI;
            end
          end
          ST_DATA_HI: begin
            hi    <= i_rx_data;
            sum   <= sum_next;
            state <= ST_DATA_LO;
          end
          ST_DATA_LO: begin
            // Single-port RAM: stall the source during the write cycle.
            sum        <= sum_next;
            o_mem_data <= {hi, i_rx_data};
            o_mem_addr <= idx[ADDR_WIDTH-1:0];
            o_mem_we   <= 1'b1;
            o_rx_ready <= 1'b0;
            idx        <= idx + IDX_W'(1);
            state      <= last_word ? ST_CHECKSUM : ST_DATA_HI;
          end
          ST_CHECKSUM: begin
            if (sum_next == 8'h00) begin
              state       <= ST_DONE;
              o_done      <= 1'b1;
              o_core_hold <= 1'b0;
            end else begin
              state   <= ST_ERROR;
              o_error <= 1'b1;
            end
          end
          ST_DONE, ST_ERROR: begin
            if (i_rx_data == MAGIC) begin
              state       <= ST_LEN_HI;
              o_done      <= 1'b0;
              o_error     <= 1'b0;
              o_core_hold <= 1'b1;
              sum         <= '0;
              idx         <= '0;
            end
          end
          default: state <= ST_WAIT_MAGIC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: scoreboard of expected RAM writes
// checked on every clock, plus per-scenario status checks.
`timescale 1ns/1ps
module tb_program_loader;

  localparam int unsigned AW = 8;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic          core_hold;
  logic          done;
  logic          error;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] frame_words[4];

  program_loader #(
    .ADDR_WIDTH    (AW),
    .MAGIC         (8'hA5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_rx_valid (rx_valid),
    .i_rx_data  (rx_data),
    .o_rx_ready (rx_ready),
    .o_mem_we   (mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_data (mem_data),
    .o_core_hold(core_hold),
    .o_done     (done),
    .o_error    (error)
  );

  always #5 clk = ~clk;

  // Advance one clock and compare any RAM write against the scoreboard.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, none expected", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          errors++;
          $display("FAIL mem_write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                   mem_addr, mem_data, e.addr, e.data);
        end
      end
      checks++;
      if (rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_during_write: got %b, expected 0", rx_ready);
      end
    end
  endtask

  // Offer one byte and wait (bounded) until it is accepted.
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!acc && n < 20) begin
      acc = rx_ready;
      tick();
      n++;
    end
    rx_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: byte %0h not accepted within 20 cycles", b);
    end
  endtask

  // Send a full frame from frame_words; expected writes go to the scoreboard.
  task automatic send_frame(input logic [15:0] len, input int nw, input logic bad);
    logic [7:0] sum;
    sum = len[15:8] + len[7:0];
    send_byte(8'hA5);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back({AW'(i), frame_words[i]});
      send_byte(frame_words[i][15:8]);
      send_byte(frame_words[i][7:0]);
      sum = sum + frame_words[i][15:8] + frame_words[i][7:0];
    end
    send_byte(8'(8'h00 - sum) + (bad ? 8'h01 : 8'h00));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) tick();
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, expected 0", rx_ready); end
    checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL reset_hold: got %b, expected 1", core_hold); end
    checks++; if ({done, error, mem_we} !== 3'b000) begin errors++; $display("FAIL reset_flags: got done/err/we=%b, expected 000", {done, error, mem_we}); end
    checks++; if ({mem_addr, mem_data} !== '0) begin errors++; $display("FAIL reset_addr_data: got %0h/%0h, expected 0/0", mem_addr, mem_data); end
    reset = 1'b0;
    tick();
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b, expected 1", rx_ready); end
  endtask

  task automatic test_good_frame();
    frame_words[0] = 16'h1234;
    frame_words[1] = 16'hABCD;
    send_frame(16'd2, 2, 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL good_done: got %b, expected 1", done); end
    checks++; if (core_hold !== 1'b0) begin errors++; $display("FAIL good_hold: got %b, expected 0", core_hold); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL good_error: got %b, expected 0", error); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL good_writes: %0d writes missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_bad_checksum();
    send_byte(8'hA5);
    tick();
    checks++; if ({core_hold, done} !== 2'b10) begin errors++; $display("FAIL restart_hold_done: got %b, expected 10", {core_hold, done}); end
    send_byte(8'h00);
    send_byte(8'h02);
    exp_q.push_back({AW'(0), 16'h1234});
    send_byte(8'h12); send_byte(8'h34);
    exp_q.push_back({AW'(1), 16'hABCD});
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h41);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL badchk_error: got %b, expected 1", error); end
    checks++; if ({core_hold, done} !== 2'b10) begin errors++; $display("FAIL badchk_hold_done: got %b, expected 10", {core_hold, done}); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL badchk_writes: %0d writes missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_length_error();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL len_error: got %b, expected 1", error); end
    checks++; if ({core_hold, done} !== 2'b10) begin errors++; $display("FAIL len_hold_done: got %b, expected 10", {core_hold, done}); end
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (3) tick();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL len_stays_error: got %b, expected 1", error); end
  endtask

  task automatic test_zero_length();
    send_byte(8'h00);
    send_byte(8'hFF);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL stray_ignored: got error=%b, expected 1", error); end
    send_frame(16'd0, 0, 1'b0);
    checks++; if ({done, error, core_hold} !== 3'b100) begin errors++; $display("FAIL zero_len_status: got done/err/hold=%b, expected 100", {done, error, core_hold}); end
  endtask

  task automatic test_timeout();
    int n;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    repeat (8) tick();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_early: got error=%b after 8 idle, expected 0", error); end
    n = 8;
    while (error !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (error !== 1'b1 || n < 16 || n > 17) begin errors++; $display("FAIL timeout_fire: error=%b after %0d idle cycles, expected 1 after 16..17", error, n); end
    checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL timeout_hold: got %b, expected 1", core_hold); end
    frame_words[0] = 16'hBEEF;
    send_frame(16'd1, 1, 1'b0);
    checks++; if ({done, error, core_hold} !== 3'b100) begin errors++; $display("FAIL timeout_reload: got done/err/hold=%b, expected 100", {done, error, core_hold}); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_writes: %0d writes missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_load();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    exp_q.push_back({AW'(0), 16'h1122});
    send_byte(8'h11);
    send_byte(8'h22);
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    reset    = 1'b1;
    #1;
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b, expected 0", rx_ready); end
    checks++; if ({core_hold, done, error} !== 3'b100) begin errors++; $display("FAIL midrst_status: got hold/done/err=%b, expected 100", {core_hold, done, error}); end
    repeat (2) tick();
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_held: got %b, expected 0", rx_ready); end
    reset    = 1'b0;
    rx_valid = 1'b0;
    tick();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h33); send_byte(8'h44);
    repeat (2) tick();
    checks++; if ({core_hold, done} !== 2'b10) begin errors++; $display("FAIL midrst_needs_frame: got hold/done=%b, expected 10", {core_hold, done}); end
    frame_words[0] = 16'h55AA;
    frame_words[1] = 16'h0F0F;
    send_frame(16'd2, 2, 1'b0);
    checks++; if ({done, error, core_hold} !== 3'b100) begin errors++; $display("FAIL midrst_reload: got done/err/hold=%b, expected 100", {done, error, core_hold}); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_writes: %0d writes missing, expected 0", exp_q.size()); end
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_length_error();
    test_zero_length();
    test_timeout();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
